// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: schedules a radix-2 DIT in-place FFT (stage-major, butterfly
// index ascending) as a stream of butterfly descriptors with valid/ready
// handshake. A twiddle ROM read is issued one cycle ahead of each descriptor so
// registered ROM data lines up with o_valid. LOG2N must be at least 2.
// Build option: define FFT_CTRL_STALL_CNT_EN to add the o_stall_cnt output.
module fft_stage_ctrl #(
  parameter int LOG2N     = 10,
  parameter int STAGE_GAP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [3:0]       o_stage,
  output logic             o_tw_rd_en,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_busy,
  output logic             o_done
`ifdef FFT_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      o_stall_cnt
`endif
);

  localparam int              JW         = LOG2N - 1;
  localparam logic [JW-1:0]   LAST_J     = '1;
  localparam logic [3:0]      LAST_STAGE = 4'(LOG2N - 1);
  localparam logic [3:0]      GAP_LAST   = 4'(STAGE_GAP - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Upper-leg address: group base g*2h plus offset p inside the group.
  function automatic logic [LOG2N-1:0] addrAOf(input logic [3:0] s, input logic [JW-1:0] j);
    logic [LOG2N-1:0] jw;
    logic [LOG2N-1:0] mask;
    jw   = {1'b0, j};
    mask = (LOG2N'(1) << s) - LOG2N'(1);
    return ((jw >> s) << ({1'b0, s} + 5'd1)) | (jw & mask);
  endfunction

  // Twiddle index: offset p inside the group scaled up to the N/2-entry table.
  function automatic logic [JW-1:0] twOf(input logic [3:0] s, input logic [JW-1:0] j);
    logic [JW-1:0] mask;
    mask = (JW'(1) << s) - JW'(1);
    return (j & mask) << (5'(JW) - {1'b0, s});
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       stage_q, stage_d;
  logic [JW-1:0]    j_q, j_d;
  logic             more_q, more_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic             outValid_q, outValid_d;
  logic             outLast_q, outLast_d;
  logic [3:0]       outStage_q, outStage_d;
  logic [LOG2N-1:0] outAddrA_q, outAddrA_d;
  logic [LOG2N-1:0] outAddrB_q, outAddrB_d;
  logic [JW-1:0]    outTw_q, outTw_d;

  logic          xfer, stall, advance, stageDone;
  logic          issValid, issue, startNext;
  logic [3:0]    issStage;
  logic [JW-1:0] issJ;

  assign xfer      = outValid_q & i_ready;
  assign stall     = outValid_q & ~i_ready;
  assign advance   = ~stall;
  assign stageDone = xfer & outLast_q;

  // Choose the butterfly offered to the issue slot; the first butterfly of the
  // next stage is issued in the last gap cycle so o_valid stays low exactly
  // STAGE_GAP cycles between stages.
  always_comb begin
    issValid  = 1'b0;
    startNext = 1'b0;
    issStage  = stage_q;
    issJ      = j_q;
    case (state_q)
      ST_RUN: begin
        if (more_q) begin
          issValid = 1'b1;
        end else if (stageDone && (stage_q != LAST_STAGE) && (STAGE_GAP == 0)) begin
          issValid  = 1'b1;
          startNext = 1'b1;
          issStage  = stage_q + 4'd1;
          issJ      = '0;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          issValid  = 1'b1;
          startNext = 1'b1;
          issStage  = stage_q + 4'd1;
          issJ      = '0;
        end
      end
      default: ;
    endcase
  end

  assign issue = issValid & advance;

  // Twiddle ROM request: re-read the held entry while stalled, else the new issue.
  always_comb begin
    o_tw_rd_en = 1'b0;
    o_tw_addr  = '0;
    if (stall) begin
      o_tw_rd_en = 1'b1;
      o_tw_addr  = outTw_q;
    end else if (issue) begin
      o_tw_rd_en = 1'b1;
      o_tw_addr  = twOf(issStage, issJ);
    end
  end

  // Next-state logic for the descriptor slot, the index generator and the FSM.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    j_d        = j_q;
    more_d     = more_q;
    gapCnt_d   = gapCnt_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    outStage_d = outStage_q;
    outAddrA_d = outAddrA_q;
    outAddrB_d = outAddrB_q;
    outTw_d    = outTw_q;

    if (advance) begin
      outValid_d = issue;
      outLast_d  = issue && (issJ == LAST_J);
      outStage_d = issue ? issStage : 4'd0;
      outAddrA_d = issue ? addrAOf(issStage, issJ) : '0;
      outAddrB_d = issue ? (addrAOf(issStage, issJ) | (LOG2N'(1) << issStage)) : '0;
      outTw_d    = issue ? twOf(issStage, issJ) : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          stage_d = '0;
          j_d     = '0;
          more_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue && more_q) begin
          if (j_q == LAST_J) more_d = 1'b0;
          else               j_d    = j_q + 1'b1;
        end
        if (stageDone) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else if (STAGE_GAP != 0) begin
            state_d  = ST_GAP;
            gapCnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        gapCnt_d = gapCnt_q + 1'b1;
        if (startNext) state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (startNext && issue) begin
      stage_d = stage_q + 4'd1;
      j_d     = JW'(1);
      more_d  = 1'b1;
    end
  end

  // State registers with synchronous reset that drops any pending butterflies.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      j_q        <= '0;
      more_q     <= 1'b0;
      gapCnt_q   <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outStage_q <= '0;
      outAddrA_q <= '0;
      outAddrB_q <= '0;
      outTw_q    <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      j_q        <= j_d;
      more_q     <= more_d;
      gapCnt_q   <= gapCnt_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      outStage_q <= outStage_d;
      outAddrA_q <= outAddrA_d;
      outAddrB_q <= outAddrB_d;
      outTw_q    <= outTw_d;
    end
  end

  assign o_valid  = outValid_q;
  assign o_addr_a = outAddrA_q;
  assign o_addr_b = outAddrB_q;
  assign o_stage  = outStage_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);

`ifdef FFT_CTRL_STALL_CNT_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  // Saturating count of back-pressured cycles, restarted by each accepted start.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((state_q == ST_IDLE) && i_start)       stallCnt_d = '0;
    else if (stall && (stallCnt_q != 16'hFFFF)) stallCnt_d = stallCnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) stallCnt_q <= '0;
    else       stallCnt_q <= stallCnt_d;
  end

  assign o_stall_cnt = stallCnt_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl: a reference list of every butterfly is built
// with plain arithmetic, a registered twiddle ROM is modelled, and every cycle
// the DUT outputs are compared against that list and the handshake rules.
module tb_fft_stage_ctrl;

  localparam int LOG2N     = 10;
  localparam int STAGE_GAP = 4;
  localparam int HALF      = 1 << (LOG2N - 1);
  localparam int TOTAL     = LOG2N * HALF;
  localparam int RUN_LEN   = 2 + TOTAL + (LOG2N - 1) * STAGE_GAP;

  typedef struct {
    int stage;
    int a;
    int b;
    int tw;
  } desc_t;

  logic             clk = 1'b0;
  logic             rst, start, ready;
  logic             valid, twRdEn, busy, done;
  logic [LOG2N-1:0] addrA, addrB;
  logic [3:0]       stage;
  logic [LOG2N-2:0] twAddr;
  logic [15:0]      twData = 16'h0;
`ifdef FFT_CTRL_STALL_CNT_EN
  logic [15:0]      stallCnt;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  desc_t expQ[$];
  int    idx = 0;
  bit    running = 1'b0;
  bit    doneDue = 1'b0;
  bit    stageEnd = 1'b0;
  int    gapCnt = 0;
  int    expStall = 0;
  logic  prevRdEn = 1'b0;
  logic [LOG2N-2:0] prevTwAddr = '0;
  bit    prevRst = 1'b1;
  int    startCycle = 0;
  int    doneCycle = 0;
  bit    doneSeen = 1'b0;
  int    budget;
  int    burst;
  int    dirS[3]  = '{9, 0, 3};
  int    dirJ[3]  = '{5, 5, 13};
  int    dirA[3]  = '{5, 10, 21};
  int    dirB[3]  = '{517, 11, 29};
  int    dirTw[3] = '{5, 0, 320};

  // Free-running clock.
  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2N(LOG2N), .STAGE_GAP(STAGE_GAP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_ready    (ready),
    .o_valid    (valid),
    .o_addr_a   (addrA),
    .o_addr_b   (addrB),
    .o_stage    (stage),
    .o_tw_rd_en (twRdEn),
    .o_tw_addr  (twAddr),
    .o_busy     (busy),
    .o_done     (done)
`ifdef FFT_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt(stallCnt)
`endif
  );

  // Twiddle ROM contents: an injective pattern so a wrong address shows up.
  function automatic logic [15:0] romFn(input logic [LOG2N-2:0] a);
    return (16'(a) * 16'd37 + 16'd11) ^ 16'h5A5A;
  endfunction

  // Registered twiddle ROM that reads zero when not enabled.
  always @(posedge clk) twData <= twRdEn ? romFn(twAddr) : 16'h0;

  // Whole schedule written straight from the butterfly formulas.
  function automatic void buildModel();
    desc_t d;
    int h;
    expQ.delete();
    for (int s = 0; s < LOG2N; s++) begin
      h = 2 ** s;
      for (int j = 0; j < HALF; j++) begin
        d.stage = s;
        d.a     = (j / h) * 2 * h + (j % h);
        d.b     = d.a + h;
        d.tw    = (j % h) * (2 ** (LOG2N - 1 - s));
        expQ.push_back(d);
      end
    end
  endfunction

  // One comparison with counting and reporting.
  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the coming cycle shortly after the clock edge.
  task automatic applyStimulus(input bit r, input bit s, input bit x);
    @(posedge clk);
    #1;
    ready = r;
    start = s;
    rst   = x;
  endtask

  // Sample mid-cycle, compare with the reference and advance the reference.
  task automatic checkOutput();
    desc_t e;
    bit    finalXfer;
    bit    wasRunning;
    bit    wasDone;
    @(negedge clk);
    cyc++;
    finalXfer  = 1'b0;
    wasRunning = running;
    wasDone    = doneDue;
    expectEq("busy", 32'(busy), 32'(running));
    expectEq("done", 32'(done), 32'(doneDue));
    if (!prevRst) expectEq("twEnAlign", 32'(prevRdEn), 32'(valid));
    if (!twRdEn) expectEq("twAddrIdle", 32'(twAddr), 32'd0);
    if (done) begin
      doneSeen  = 1'b1;
      doneCycle = cyc;
`ifdef FFT_CTRL_STALL_CNT_EN
      expectEq("stallCnt", 32'(stallCnt), 32'(expStall));
`endif
    end
    if (valid) begin
      if (idx >= TOTAL) begin
        expectEq("extraValid", 32'(valid), 32'd0);
      end else begin
        e = expQ[idx];
        expectEq("stage", 32'(stage), 32'(e.stage));
        expectEq("addrA", 32'(addrA), 32'(e.a));
        expectEq("addrB", 32'(addrB), 32'(e.b));
        expectEq("twData", 32'(twData), 32'(romFn((LOG2N-1)'(e.tw))));
        for (int k = 0; k < 3; k++) begin
          if (idx == dirS[k] * HALF + dirJ[k]) begin
            expectEq("dirAddrA", 32'(addrA), 32'(dirA[k]));
            expectEq("dirAddrB", 32'(addrB), 32'(dirB[k]));
            expectEq("dirTw", 32'(prevTwAddr), 32'(dirTw[k]));
          end
        end
        if (stageEnd) begin
          expectEq("gapLen", 32'(gapCnt), 32'(STAGE_GAP));
          stageEnd = 1'b0;
        end
        if (ready) begin
          idx++;
          if (idx == TOTAL) finalXfer = 1'b1;
          else if (idx % HALF == 0) begin
            stageEnd = 1'b1;
            gapCnt   = 0;
          end
        end else begin
          expStall++;
        end
      end
    end else if (stageEnd) begin
      gapCnt++;
    end
    if (rst) begin
      running  = 1'b0;
      doneDue  = 1'b0;
      stageEnd = 1'b0;
    end else begin
      doneDue = finalXfer;
      if (wasDone) running = 1'b0;
      if (start && !wasRunning) begin
        running    = 1'b1;
        idx        = 0;
        stageEnd   = 1'b0;
        gapCnt     = 0;
        expStall   = 0;
        startCycle = cyc;
      end
    end
    prevRdEn   = twRdEn;
    prevTwAddr = twAddr;
    prevRst    = rst;
  endtask

  // All outputs at their idle/reset values.
  task automatic checkIdle(input string tag);
    expectEq({tag, "Valid"}, 32'(valid), 32'd0);
    expectEq({tag, "TwEn"}, 32'(twRdEn), 32'd0);
    expectEq({tag, "Busy"}, 32'(busy), 32'd0);
    expectEq({tag, "Done"}, 32'(done), 32'd0);
    expectEq({tag, "AddrA"}, 32'(addrA), 32'd0);
    expectEq({tag, "AddrB"}, 32'(addrB), 32'd0);
    expectEq({tag, "Stage"}, 32'(stage), 32'd0);
    expectEq({tag, "TwAddr"}, 32'(twAddr), 32'd0);
  endtask

  // Directed sequence: reset, full-rate run, mid-stage reset, back-pressured run.
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    buildModel();
    $display("[TB] reference schedule holds %0d butterflies", expQ.size());

    checkOutput();
    checkIdle("reset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();

    // Full-rate schedule with the first-issue latency checked explicitly.
    doneSeen = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    expectEq("firstTwEn", 32'(twRdEn), 32'd1);
    expectEq("firstTwAddr", 32'(twAddr), 32'd0);
    expectEq("firstValidLow", 32'(valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    expectEq("firstValid", 32'(valid), 32'd1);
    expectEq("firstAddrA", 32'(addrA), 32'd0);
    expectEq("firstAddrB", 32'(addrB), 32'd1);
    budget = 0;
    while (!doneSeen && budget < 8000) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput();
      budget++;
    end
    expectEq("run1Done", 32'(doneSeen), 32'd1);
    expectEq("run1Len", 32'(doneCycle - startCycle), 32'(RUN_LEN));
    expectEq("run1Count", 32'(idx), 32'(TOTAL));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();

    // Abort in the middle of stage 4 and confirm everything clears.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput();
    budget = 0;
    while (idx < 4 * HALF + 100 && budget < 6000) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'b0, 1'b0);
      checkOutput();
      budget++;
    end
    expectEq("abortStage", 32'(stage), 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    checkIdle("abort");

    // Replay from the beginning under random back-pressure and stray starts.
    doneSeen = 1'b0;
    burst    = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput();
    budget = 0;
    while (!doneSeen && budget < 20000) begin
      if (burst == 0 && $urandom_range(0, 63) == 0) burst = $urandom_range(2, 9);
      if (burst > 0) begin
        burst--;
        applyStimulus(1'b0, running && ($urandom_range(0, 31) == 0), 1'b0);
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, running && ($urandom_range(0, 31) == 0), 1'b0);
      end
      checkOutput();
      budget++;
    end
    expectEq("run2Done", 32'(doneSeen), 32'd1);
    expectEq("run2Count", 32'(idx), 32'(TOTAL));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    checkIdle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
